video_timing_generator: RTL and testbench

//  Parametrised raster timing generator for parallel-RGB TFT panels in the pixel clock domain.

---
 rtl/video_timing_generator.sv | 131 +++++++++++++
 tb/tb_video_timing_generator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_generator.sv
// Raster timing generator: sync/DE, pixel coordinates, prefetch strobes and panel reset sequencing.
// Optional panel reset sequencer enabled by defining VTC_PANEL_RESET_EN.
module video_timing_generator #(
    parameter int unsigned H_ACTIVE      = 1024,
    parameter int unsigned H_PULSE       = 10,
    parameter int unsigned H_BACK        = 150,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned V_ACTIVE      = 600,
    parameter int unsigned V_PULSE       = 2,
    parameter int unsigned V_BACK        = 21,
    parameter int unsigned V_FRONT       = 64,
    parameter bit          HSYNC_POL     = 1'b0,
    parameter bit          VSYNC_POL     = 1'b0,
    parameter int unsigned PREFETCH_LEAD = 4,
    parameter int unsigned RESET_FRAMES  = 2,
    localparam int unsigned H_TOTAL = H_PULSE + H_BACK + H_ACTIVE + H_FRONT,
    localparam int unsigned V_TOTAL = V_PULSE + V_BACK + V_ACTIVE + V_FRONT,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          i_pixel_clk,
    input  logic          i_reset,
    input  logic          i_enable,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [HW-1:0] o_x,
    output logic [VW-1:0] o_y,
    output logic          o_pixel_first,
    output logic          o_pixel_last,
    output logic          o_prefetch_start,
    output logic          o_row_first,
    output logic          o_row_last,
    output logic          o_frame_start,
    output logic          o_vblank_start,
    output logic          o_panel_reset_n
);

    localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HSyncEnd  = HW'(H_PULSE);
    localparam logic [HW-1:0] HDeBeg    = HW'(H_PULSE + H_BACK);
    localparam logic [HW-1:0] HDeEnd    = HW'(H_PULSE + H_BACK + H_ACTIVE);
    localparam logic [HW-1:0] HFirst    = HW'(H_PULSE + H_BACK - PREFETCH_LEAD);
    localparam logic [HW-1:0] HLastPre  = HW'(H_PULSE + H_BACK + H_ACTIVE - 1 - PREFETCH_LEAD);
    localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VSyncEnd  = VW'(V_PULSE);
    localparam logic [VW-1:0] VDeBeg    = VW'(V_PULSE + V_BACK);
    localparam logic [VW-1:0] VDeEnd    = VW'(V_PULSE + V_BACK + V_ACTIVE);
    localparam logic [VW-1:0] VRowFirst = VW'(V_PULSE + V_BACK - 1);
    localparam logic [VW-1:0] VRowLast  = VW'(V_PULSE + V_BACK + V_ACTIVE - 2);
    localparam logic [VW-1:0] VLastAct  = VW'(V_PULSE + V_BACK + V_ACTIVE - 1);

    if (RESET_FRAMES < 1 || PREFETCH_LEAD < 1 || PREFETCH_LEAD >= H_BACK) begin : g_param_check
        $error("video_timing_generator: RESET_FRAMES or PREFETCH_LEAD out of range");
    end

    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    logic          h_act;
    logic          v_act;

    always_comb begin
        h_act = (h_q >= HDeBeg) && (h_q < HDeEnd);
        v_act = (v_q >= VDeBeg) && (v_q < VDeEnd);
    end

    // Disabled generator parks at the frame origin so restart begins a fresh frame.
    always_ff @(posedge i_pixel_clk) begin
        if (i_reset || !i_enable) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == HLast) begin
            h_q <= '0;
            v_q <= (v_q == VLast) ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    always_ff @(posedge i_pixel_clk) begin
        if (i_reset || !i_enable) begin
            o_hsync          <= ~HSYNC_POL;
            o_vsync          <= ~VSYNC_POL;
            o_de             <= 1'b0;
            o_x              <= '0;
            o_y              <= '0;
            o_pixel_first    <= 1'b0;
            o_pixel_last     <= 1'b0;
            o_prefetch_start <= 1'b0;
            o_row_first      <= 1'b0;
            o_row_last       <= 1'b0;
            o_frame_start    <= 1'b0;
            o_vblank_start   <= 1'b0;
        end else begin
            o_hsync          <= (h_q < HSyncEnd) ? HSYNC_POL : ~HSYNC_POL;
            o_vsync          <= (v_q < VSyncEnd) ? VSYNC_POL : ~VSYNC_POL;
            o_de             <= h_act && v_act;
            o_x              <= (h_act && v_act) ? h_q - HDeBeg : '0;
            o_y              <= v_act ? v_q - VDeBeg : '0;
            o_pixel_first    <= v_act && (h_q == HFirst);
            o_pixel_last     <= v_act && (h_q == HLastPre);
            o_prefetch_start <= (h_q == HDeEnd);
            o_row_first      <= (v_q == VRowFirst);
            o_row_last       <= (v_q == VRowLast);
            o_frame_start    <= (h_q == '0) && (v_q == '0);
            o_vblank_start   <= (h_q == HDeEnd) && (v_q == VLastAct);
        end
    end

`ifdef VTC_PANEL_RESET_EN
    localparam int unsigned FW = $clog2(RESET_FRAMES + 1);

    logic [FW-1:0] frames_q;

    // Counts registered frame_start pulses, so release lands one clock after the last one.
    always_ff @(posedge i_pixel_clk) begin
        if (i_reset) begin
            frames_q        <= '0;
            o_panel_reset_n <= 1'b0;
        end else if (!o_panel_reset_n && o_frame_start) begin
            frames_q <= frames_q + 1'b1;
            if (frames_q == FW'(RESET_FRAMES - 1)) begin
                o_panel_reset_n <= 1'b1;
            end
        end
    end
`else
    assign o_panel_reset_n = 1'b1;
`endif

endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboard bench for video_timing_generator on a small 15x8 raster (lead 2, active-low syncs).
module tb_video_timing_generator;

    localparam int HW = 4;
    localparam int VW = 3;

`ifdef VTC_PANEL_RESET_EN
    localparam bit PanelEn = 1'b1;
`else
    localparam bit PanelEn = 1'b0;
`endif

    localparam int KFs = 0, KHsF = 1, KHsR = 2, KVsF = 3, KVsR = 4, KDeR = 5, KDeF = 6;
    localparam int KPf = 7, KPl = 8, KPs = 9, KVb = 10, KRfR = 11, KRfF = 12, KRlR = 13;
    localparam int KRlF = 14, KPrR = 15, KPrF = 16;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } exp_t;

    exp_t sb[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          o_hsync, o_vsync, o_de;
    logic [HW-1:0] o_x;
    logic [VW-1:0] o_y;
    logic          o_pixel_first, o_pixel_last, o_prefetch_start, o_row_first, o_row_last;
    logic          o_frame_start, o_vblank_start, o_panel_reset_n;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    video_timing_generator #(
        .H_ACTIVE(8), .H_PULSE(2), .H_BACK(3), .H_FRONT(2),
        .V_ACTIVE(4), .V_PULSE(1), .V_BACK(2), .V_FRONT(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PREFETCH_LEAD(2), .RESET_FRAMES(2)
    ) dut (
        .i_pixel_clk     (clk),
        .i_reset         (rst),
        .i_enable        (en),
        .o_hsync         (o_hsync),
        .o_vsync         (o_vsync),
        .o_de            (o_de),
        .o_x             (o_x),
        .o_y             (o_y),
        .o_pixel_first   (o_pixel_first),
        .o_pixel_last    (o_pixel_last),
        .o_prefetch_start(o_prefetch_start),
        .o_row_first     (o_row_first),
        .o_row_last      (o_row_last),
        .o_frame_start   (o_frame_start),
        .o_vblank_start  (o_vblank_start),
        .o_panel_reset_n (o_panel_reset_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            KFs: return "frame_start";     KHsF: return "hsync_fall";  KHsR: return "hsync_rise";
            KVsF: return "vsync_fall";     KVsR: return "vsync_rise";  KDeR: return "de_rise";
            KDeF: return "de_fall";        KPf: return "pixel_first";  KPl: return "pixel_last";
            KPs: return "prefetch_start";  KVb: return "vblank_start"; KRfR: return "row_first_rise";
            KRfF: return "row_first_fall"; KRlR: return "row_last_rise";
            KRlF: return "row_last_fall";  KPrR: return "panel_rst_rise";
            default: return "panel_rst_fall";
        endcase
    endfunction

    task automatic push(input int k, input int c, input int v);
        sb.push_back('{kind: k, cyc: c, val: v});
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic check_ev(input int k, input int c, input int v);
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].kind == k) idx = i;
        n_checks++;
        if (idx < 0) begin
            $display("FAIL %s: unexpected event at cycle %0d val %0d", kname(k), c, v);
        end else begin
            if (sb[idx].cyc == c && sb[idx].val == v) n_pass++;
            else $display("FAIL %s: got cycle %0d val %0d, expected cycle %0d val %0d",
                          kname(k), c, v, sb[idx].cyc, sb[idx].val);
            sb.delete(idx);
        end
    endtask

    // Hand-derived offsets: DE h=5..12, pixel_first h=3, pixel_last h=10, front porch h=13,
    // active lines v=3..6, row_first v=2, row_last v=5; output index k = 15*v + h.
    task automatic push_frame(input int b);
        push(KFs, b, 0);
        push(KVsF, b, 0);
        push(KVsR, b + 15, 0);
        push(KRfR, b + 30, 0);
        push(KRfF, b + 45, 0);
        push(KRlR, b + 75, 0);
        push(KRlF, b + 90, 0);
        push(KVb, b + 103, 0);
        for (int v = 0; v < 8; v++) begin
            push(KHsF, b + 15 * v, 0);
            push(KHsR, b + 15 * v + 2, 0);
            push(KPs, b + 15 * v + 13, 0);
            if (v >= 3 && v <= 6) begin
                push(KPf, b + 15 * v + 3, 0);
                push(KDeR, b + 15 * v + 5, v - 3);
                push(KPl, b + 15 * v + 10, 0);
                push(KDeF, b + 15 * v + 13, 7);
            end
        end
    endtask

    task automatic snap(input string nm, input int panel_exp);
        chk({nm, "_flags"}, int'({o_hsync, o_vsync, o_de, o_pixel_first, o_pixel_last,
                                  o_prefetch_start, o_row_first, o_row_last, o_frame_start,
                                  o_vblank_start}), 'h300);
        chk({nm, "_x"}, int'(o_x), 0);
        chk({nm, "_y"}, int'(o_y), 0);
        chk({nm, "_panel_reset_n"}, int'(o_panel_reset_n), panel_exp);
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Monitor: every observed edge or pulse is matched against the scoreboard.
    logic hs_p = 1'b1, vs_p = 1'b1, de_p = 1'b0, rf_p = 1'b0, rl_p = 1'b0;
    logic pr_p = !PanelEn;
    int   last_x = 0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (o_frame_start) check_ev(KFs, cyc, 0);
            if (hs_p && !o_hsync) check_ev(KHsF, cyc, 0);
            if (!hs_p && o_hsync) check_ev(KHsR, cyc, 0);
            if (vs_p && !o_vsync) check_ev(KVsF, cyc, 0);
            if (!vs_p && o_vsync) check_ev(KVsR, cyc, 0);
            if (o_de && !de_p) check_ev(KDeR, cyc, int'(o_x) * 256 + int'(o_y));
            if (!o_de && de_p) check_ev(KDeF, cyc, last_x);
            if (o_pixel_first) check_ev(KPf, cyc, 0);
            if (o_pixel_last) check_ev(KPl, cyc, 0);
            if (o_prefetch_start) check_ev(KPs, cyc, 0);
            if (o_vblank_start) check_ev(KVb, cyc, 0);
            if (o_row_first && !rf_p) check_ev(KRfR, cyc, 0);
            if (!o_row_first && rf_p) check_ev(KRfF, cyc, 0);
            if (o_row_last && !rl_p) check_ev(KRlR, cyc, 0);
            if (!o_row_last && rl_p) check_ev(KRlF, cyc, 0);
            if (o_panel_reset_n && !pr_p) check_ev(KPrR, cyc, 0);
            if (!o_panel_reset_n && pr_p) check_ev(KPrF, cyc, 0);
            if (o_de) last_x <= int'(o_x);
            hs_p <= o_hsync;
            vs_p <= o_vsync;
            de_p <= o_de;
            rf_p <= o_row_first;
            rl_p <= o_row_last;
            pr_p <= o_panel_reset_n;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, b2, b3;
        repeat (3) @(negedge clk);
        snap("reset", PanelEn ? 0 : 1);

        // Two full frames, then the head of a third that gets cut short by disable.
        b = cyc + 1;
        push_frame(b);
        push_frame(b + 120);
        push(KFs, b + 240, 0);
        push(KVsF, b + 240, 0);
        push(KHsF, b + 240, 0);
        push(KHsR, b + 242, 0);
        push(KVsR, b + 246, 0);
`ifdef VTC_PANEL_RESET_EN
        push(KPrR, b + 121, 0);
`endif
        rst = 1'b0;

        wait_cyc(b + 245);
        en = 1'b0;
        wait_cyc(b + 246);
        snap("idle", 1);
        wait_cyc(b + 247);
        snap("idle2", 1);

        b2 = b + 249;
        push_frame(b2);
        push(KFs, b2 + 120, 0);
        push(KVsF, b2 + 120, 0);
        push(KHsF, b2 + 120, 0);
        push(KHsR, b2 + 122, 0);
        push(KVsR, b2 + 126, 0);
`ifdef VTC_PANEL_RESET_EN
        push(KPrF, b2 + 126, 0);
`endif
        wait_cyc(b + 248);
        en = 1'b1;

        wait_cyc(b2 + 125);
        rst = 1'b1;
        wait_cyc(b2 + 126);
        snap("midreset", PanelEn ? 0 : 1);

        b3 = b2 + 129;
        push(KFs, b3, 0);
        push(KVsF, b3, 0);
        push(KHsF, b3, 0);
        push(KHsR, b3 + 2, 0);
        push(KPs, b3 + 13, 0);
        push(KVsR, b3 + 15, 0);
        push(KHsF, b3 + 15, 0);
        push(KHsR, b3 + 17, 0);
        wait_cyc(b2 + 128);
        rst = 1'b0;

        wait_cyc(b3 + 20);
        chk("panel_after_one_frame", int'(o_panel_reset_n), PanelEn ? 0 : 1);
        foreach (sb[i]) begin
            n_checks++;
            $display("FAIL %s: expected event at cycle %0d never seen", kname(sb[i].kind),
                     sb[i].cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
